// File: rtl/sbox_lookup_sequencer.sv
// Walks one shared combinational DES S-box port across the eight 6-bit groups
// of a 48-bit round word, assembling the 32-bit substitution result MSB first.
module sbox_lookup_sequencer (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic [47:0] data_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] data_out,
   output logic [2:0]  sbox_sel,
   output logic [5:0]  sbox_din,
   input  logic [3:0]  sbox_dout
);

   typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

   state_t      state;
   logic [47:0] in_sr;
   logic [31:0] acc;
   logic [2:0]  cnt;

   // busy is a registered copy of (state == LOOKUP), so it also gates the lookup port
   assign sbox_sel = busy ? cnt : 3'd0;
   assign sbox_din = busy ? in_sr[47:42] : 6'd0;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state    <= IDLE;
         in_sr    <= '0;
         acc      <= '0;
         cnt      <= '0;
         data_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  in_sr <= data_in;
                  cnt   <= '0;
                  acc   <= '0;
                  state <= LOOKUP;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            LOOKUP: begin
               acc   <= {acc[27:0], sbox_dout};
               in_sr <= {in_sr[41:0], 6'b0};
               cnt   <= cnt + 3'd1;
               // the eighth nibble goes straight into data_out alongside acc
               if (cnt == 3'd7) begin
                  data_out <= {acc[27:0], sbox_dout};
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
